mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
// Parametrised memory slave answering the Processor memory bus (addr/data/read/write/ready).
// Holds a split address map: instruction region and data region, each a word-addressed array.
// Inserts a configurable number of wait states and flags decode/protocol errors.
// Offers a back-door load port so benches preload code and data without hierarchical pokes.
// PARAMETERS
// DATA_W        32      word width
// ADDR_W        32      bus address width (word addresses)
// IMEM_BASE     0       first address of instruction region
// IMEM_DEPTH    64      words in instruction region
// DMEM_BASE     64      first address of data region (regions must not overlap)
// DMEM_DEPTH    256     words in data region
// LATENCY       0       wait states between accept and ready (0..15)
// IMEM_WRITABLE 0       1: bus writes to instruction region allowed
// NOP_WORD      32'h0   value driven on oMemData when no read data is valid
// PORTS
// iClk       in   1       clock, rising edge
// nRst       in   1       asynchronous active-low reset
// iMemAddr   in   ADDR_W  bus address from Processor
// iMemData   in   DATA_W  bus write data
// iMemRead   in   1       read request, held until oMemRdy
// iMemWrite  in   1       write request, held until oMemRdy
// oMemData   out  DATA_W  read data, valid only in the oMemRdy cycle of a read
// oMemRdy    out  1       one-cycle completion strobe
// oMemErr    out  1       one-cycle error strobe, coincident with oMemRdy
// iLoadEn    in   1       back-door write enable
// iLoadAddr  in   ADDR_W  back-door address (same map as bus)
// iLoadData  in   DATA_W  back-door data
// BEHAVIOUR
// - Reset: FSM=IDLE, wait counter=0, oMemRdy=0, oMemErr=0, oMemData=NOP_WORD; arrays not cleared.
// - FSM IDLE->WAIT->RESP->IDLE. IDLE: accept when iMemRead|iMemWrite; latch addr, data, op.
// - Accept at edge T: LATENCY=0 goes straight to RESP; else WAIT counts LATENCY cycles.
// - oMemRdy high exactly one cycle, LATENCY+1 cycles after accept edge; registered outputs.
// - RESP read: oMemData=array word at latched addr. Otherwise oMemData=NOP_WORD.
// - RESP write: array updated at the RESP edge; no write occurs earlier.
// - Decode: addr-BASE < DEPTH selects region; unmapped address -> oMemErr=1, read data NOP_WORD, no write.
// - Write into instruction region with IMEM_WRITABLE=0 -> oMemErr=1, no write.
// - iMemRead&iMemWrite at accept -> oMemErr=1 at RESP, no access.
// - Request dropped during WAIT -> abort to IDLE, no Rdy, no write.
// - After RESP FSM returns IDLE one cycle; a still-held request is re-accepted as new access.
// - Back-door: iLoadEn writes any cycle; unmapped load ignored silently.
// - Back-door vs bus write same word same edge: bus write wins.
// - Reset mid-WAIT/RESP: FSM to IDLE immediately, pending write dropped, outputs to reset values.
// - Latched addr arithmetic in ADDR_W bits, unsigned; index = addr-BASE truncated to clog2(DEPTH).
// TESTING
// - Load imem[0]=0x1234, LATENCY=0; read addr 0 -> Rdy and data 0x1234 one cycle after accept.
// - LATENCY=3; write 55 to addr 64, read back -> Rdy 4 cycles after each accept, data 55, Err=0.
// - Read addr 400 (unmapped) -> Rdy+Err same cycle, oMemData=NOP_WORD; write there leaves arrays unchanged.
// - IMEM_WRITABLE=0, write 7 to addr 3 -> Err=1, subsequent read of addr 3 returns preload value.
// - LATENCY=5, drop iMemRead in cycle 2 of WAIT -> no Rdy; nRst low in WAIT of a write -> word unchanged, outputs reset.
// - Back-door and bus write to addr 65 same edge (9 vs 10) -> read returns 10.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed instruction/data memory slave with wait states,
// error flagging and a back-door load port.
module mem_responder #(
  parameter int          DATA_W        = 32,
  parameter int          ADDR_W        = 32,
  parameter int          IMEM_BASE     = 0,
  parameter int          IMEM_DEPTH    = 64,
  parameter int          DMEM_BASE     = 64,
  parameter int          DMEM_DEPTH    = 256,
  parameter int          LATENCY       = 0,
  parameter int          IMEM_WRITABLE = 0,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic [ADDR_W-1:0] iMemAddr,
  input  logic [DATA_W-1:0] iMemData,
  input  logic              iMemRead,
  input  logic              iMemWrite,
  output logic [DATA_W-1:0] oMemData,
  output logic              oMemRdy,
  output logic              oMemErr,
  input  logic              iLoadEn,
  input  logic [ADDR_W-1:0] iLoadAddr,
  input  logic [DATA_W-1:0] iLoadData
);

  localparam int IW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam bit IMEM_WR_EN = (IMEM_WRITABLE != 0);
  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              rdy_q, rdy_d, err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  // Region decode of the latched bus address
  logic [ADDR_W-1:0] i_off, d_off;
  logic              i_hit, d_hit;
  logic [IW-1:0]     i_idx;
  logic [DW-1:0]     d_idx;

  assign i_off = addr_q - ADDR_W'(IMEM_BASE);
  assign d_off = addr_q - ADDR_W'(DMEM_BASE);
  assign i_hit = i_off < ADDR_W'(IMEM_DEPTH);
  assign d_hit = d_off < ADDR_W'(DMEM_DEPTH);
  assign i_idx = i_off[IW-1:0];
  assign d_idx = d_off[DW-1:0];

  // Region decode of the back-door address
  logic [ADDR_W-1:0] li_off, ld_off;
  logic              li_hit, ld_hit;

  assign li_off = iLoadAddr - ADDR_W'(IMEM_BASE);
  assign ld_off = iLoadAddr - ADDR_W'(DMEM_BASE);
  assign li_hit = iLoadEn && (li_off < ADDR_W'(IMEM_DEPTH));
  assign ld_hit = iLoadEn && (ld_off < ADDR_W'(DMEM_DEPTH));

  logic resp_err, resp_rd, resp_wr, wr_imem, wr_dmem;

  assign resp_err = (rd_q && wr_q) || !(i_hit || d_hit) || (wr_q && i_hit && !IMEM_WR_EN);
  assign resp_rd  = rd_q && !resp_err;
  assign resp_wr  = wr_q && !resp_err;
  assign wr_imem  = (state_q == S_RESP) && resp_wr && i_hit;
  assign wr_dmem  = (state_q == S_RESP) && resp_wr && d_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = NOP_WORD;
    case (state_q)
      S_IDLE: begin
        if (iMemRead || iMemWrite) begin
          addr_d  = iMemAddr;
          wdata_d = iMemData;
          rd_d    = iMemRead;
          wr_d    = iMemWrite;
          cnt_d   = '0;
          state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!(iMemRead || iMemWrite)) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAT_LAST) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        rdy_d   = 1'b1;
        err_d   = resp_err;
        if (resp_rd) rdata_d = i_hit ? imem[i_idx] : dmem[d_idx];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= NOP_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus write is issued after the back-door so it wins on a same-word collision
  always_ff @(posedge iClk) begin
    if (li_hit)  imem[li_off[IW-1:0]] <= iLoadData;
    if (wr_imem) imem[i_idx]          <= wdata_q;
    if (ld_hit)  dmem[ld_off[DW-1:0]] <= iLoadData;
    if (wr_dmem) dmem[d_idx]          <= wdata_q;
  end

  assign oMemData = rdata_q;
  assign oMemRdy  = rdy_q;
  assign oMemErr  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (LATENCY 0 and 3 instances).
module tb_mem_responder;

  localparam logic [31:0] NOP = 32'h0BAD_F00D;

  logic iClk = 1'b0;
  logic nRst = 1'b0;
  always #5 iClk = ~iClk;

  logic [1:0][31:0] m_addr, m_wdata, ld_addr, ld_data, o_data;
  logic [1:0]       m_rd, m_wr, ld_en, o_rdy, o_err;

  mem_responder #(.LATENCY(0), .NOP_WORD(NOP)) u_dut0 (
    .iClk(iClk), .nRst(nRst),
    .iMemAddr(m_addr[0]), .iMemData(m_wdata[0]), .iMemRead(m_rd[0]), .iMemWrite(m_wr[0]),
    .oMemData(o_data[0]), .oMemRdy(o_rdy[0]), .oMemErr(o_err[0]),
    .iLoadEn(ld_en[0]), .iLoadAddr(ld_addr[0]), .iLoadData(ld_data[0])
  );

  mem_responder #(.LATENCY(3), .NOP_WORD(NOP)) u_dut3 (
    .iClk(iClk), .nRst(nRst),
    .iMemAddr(m_addr[1]), .iMemData(m_wdata[1]), .iMemRead(m_rd[1]), .iMemWrite(m_wr[1]),
    .oMemData(o_data[1]), .oMemRdy(o_rdy[1]), .oMemErr(o_err[1]),
    .iLoadEn(ld_en[1]), .iLoadAddr(ld_addr[1]), .iLoadData(ld_data[1])
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  // Monitor: every completion strobe must match the oldest expected response
  always @(negedge iClk) begin
    exp_t e;
    bit   got;
    for (int d = 0; d < 2; d++) begin
      if (o_rdy[d]) begin
        got = 1'b0;
        if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
        if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
        checks++;
        if (!got) begin
          errors++;
          $display("FAIL spurious_rdy dut%0d: rdy=1 at cycle %0d, required no response", d, cyc);
        end else if (o_data[d] !== e.data || o_err[d] !== e.err || cyc != e.due) begin
          errors++;
          $display("FAIL %s: data=%h err=%b cycle=%0d, required data=%h err=%b cycle=%0d",
                   e.name, o_data[d], o_err[d], cyc, e.data, e.err, e.due);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic load(input int d, input logic [31:0] a, input logic [31:0] v);
    @(negedge iClk);
    ld_en[d] = 1'b1; ld_addr[d] = a; ld_data[d] = v;
    @(negedge iClk);
    ld_en[d] = 1'b0;
  endtask

  task automatic bus_op(input int d, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] ed, input bit ee,
                        input string nm);
    exp_t e;
    int   n;
    int   lat;
    lat = (d == 0) ? 0 : 3;
    @(negedge iClk);
    m_addr[d] = a; m_wdata[d] = wd; m_rd[d] = rd; m_wr[d] = wr;
    e.data = ed; e.err = ee; e.due = cyc + 1 + lat + 1; e.name = nm;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    n = 0;
    while (!o_rdy[d] && n < 40) begin
      @(negedge iClk);
      n++;
    end
    if (!o_rdy[d]) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no rdy after %0d cycles, required rdy", nm, n);
    end
    m_rd[d] = 1'b0; m_wr[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    bit seen;
    m_addr = '0; m_wdata = '0; m_rd = '0; m_wr = '0;
    ld_en = '0; ld_addr = '0; ld_data = '0;
    repeat (3) @(negedge iClk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_rdy%0d", d), o_rdy[d], 0);
      chk($sformatf("reset_err%0d", d), o_err[d], 0);
      chk($sformatf("reset_data%0d", d), o_data[d], NOP);
    end
    @(negedge iClk);
    nRst = 1'b1;

    load(0, 0, 32'h1234);
    load(0, 63, 32'h6363);
    load(0, 319, 32'h3190);
    load(0, 65, 32'h1111);
    load(1, 3, 32'h33);
    load(1, 16, 32'hBBBB);
    load(1, 144, 32'hAAAA);
    load(1, 65, 32'h6565);
    load(1, 66, 32'd5);
    load(1, 500, 32'hFFFF);

    // LATENCY 0 instance
    bus_op(0, 1, 0, 0,   0, 32'h1234, 0, "l0_read_imem0");
    bus_op(0, 1, 0, 63,  0, 32'h6363, 0, "l0_read_imem_last");
    bus_op(0, 1, 0, 319, 0, 32'h3190, 0, "l0_read_dmem_last");
    bus_op(0, 1, 0, 320, 0, NOP,      1, "l0_read_unmapped_320");
    fork
      bus_op(0, 0, 1, 65, 32'd10, NOP, 0, "l0_bus_vs_load_write");
      begin
        @(negedge iClk);
        @(negedge iClk);
        ld_en[0] = 1'b1; ld_addr[0] = 65; ld_data[0] = 32'd9;
        @(negedge iClk);
        ld_en[0] = 1'b0;
      end
    join
    bus_op(0, 1, 0, 65, 0, 32'd10, 0, "l0_read_collision_word");

    // LATENCY 3 instance
    bus_op(1, 0, 1, 64,  32'd55, NOP,      0, "l3_write_64");
    bus_op(1, 1, 0, 64,  0,      32'd55,   0, "l3_read_64");
    bus_op(1, 1, 0, 400, 0,      NOP,      1, "l3_read_unmapped_400");
    bus_op(1, 0, 1, 400, 32'd99, NOP,      1, "l3_write_unmapped_400");
    bus_op(1, 1, 0, 144, 0,      32'hAAAA, 0, "l3_dmem_alias_untouched");
    bus_op(1, 1, 0, 16,  0,      32'hBBBB, 0, "l3_imem_alias_untouched");
    bus_op(1, 0, 1, 3,   32'd7,  NOP,      1, "l3_write_imem_protected");
    bus_op(1, 1, 0, 3,   0,      32'h33,   0, "l3_read_imem3_kept");
    bus_op(1, 1, 1, 65,  32'h77, NOP,      1, "l3_read_and_write");
    bus_op(1, 1, 0, 65,  0,      32'h6565, 0, "l3_read_65_kept");

    // Request withdrawn in the second WAIT cycle
    @(negedge iClk);
    m_addr[1] = 65; m_rd[1] = 1'b1;
    @(negedge iClk);
    @(negedge iClk);
    m_rd[1] = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge iClk);
      if (o_rdy[1]) seen = 1'b1;
    end
    chk("l3_abort_no_rdy", seen, 0);

    // Reset while a write sits in WAIT
    @(negedge iClk);
    m_addr[1] = 66; m_wdata[1] = 32'd77; m_wr[1] = 1'b1;
    @(negedge iClk);
    @(negedge iClk);
    nRst = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge iClk);
      if (o_rdy[1] || o_err[1]) seen = 1'b1;
    end
    chk("l3_reset_in_wait_quiet", seen, 0);
    m_wr[1] = 1'b0;
    nRst = 1'b1;
    bus_op(1, 1, 0, 66, 0, 32'd5, 0, "l3_read_66_after_reset");

    // Reset during the completion cycle forces outputs back at once
    bus_op(1, 1, 0, 64, 0, 32'd55, 0, "l3_read_64_before_reset");
    #1 nRst = 1'b0;
    #1;
    chk("reset_in_rdy_rdy", o_rdy[1], 0);
    chk("reset_in_rdy_err", o_err[1], 0);
    chk("reset_in_rdy_data", o_data[1], NOP);
    @(negedge iClk);
    nRst = 1'b1;

    repeat (8) @(negedge iClk);
    chk("pending_responses", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
